// File: rtl/elevator_motion_ctrl.sv
// Cabin motion and door controller: walks the cabin floor by floor toward the
// arbiter's target, opens the door at requested floors and keeps sweep direction.
module elevator_motion_ctrl #(
  parameter int unsigned FLOORS_NUM          = 5,
  parameter int unsigned FLOOR_TRAVEL_CYCLES = 8,
  parameter int unsigned DOOR_OPEN_CYCLES    = 4,
  localparam int unsigned FW                 = $clog2(FLOORS_NUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FW-1:0]         req_floor,
  input  logic [FLOORS_NUM-1:0] req_vec,
  input  logic                  door_hold,
  output logic [FW-1:0]         curr_floor,
  output logic                  up,
  output logic                  down,
  output logic [FLOORS_NUM-1:0] request_done,
  output logic                  door_open,
  output logic                  moving
);

  localparam int unsigned TW = $clog2(FLOOR_TRAVEL_CYCLES + 1);
  localparam int unsigned DW = $clog2(DOOR_OPEN_CYCLES + 1);

  localparam logic [FW:0]             FloorsNum = (FW + 1)'(FLOORS_NUM);
  localparam logic [FW-1:0]           TopFloor  = FW'(FLOORS_NUM - 1);
  localparam logic [TW-1:0]           TravLast  = TW'(FLOOR_TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0]           DwellLast = DW'(DOOR_OPEN_CYCLES - 1);
  localparam logic [FLOORS_NUM-1:0]   OneHot0   = FLOORS_NUM'(1);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StMoveUp   = 2'd1;
  localparam logic [1:0] StMoveDown = 2'd2;
  localparam logic [1:0] StDoorOpen = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [FW-1:0]         floor_q, floor_d;
  logic                  up_q, up_d;
  logic                  down_q, down_d;
  logic                  door_q, door_d;
  logic                  moving_q, moving_d;
  logic [FLOORS_NUM-1:0] done_q, done_d;
  logic [TW-1:0]         trav_q, trav_d;
  logic [DW-1:0]         dwell_q, dwell_d;

  logic [FW-1:0] tgt;
  logic [FW-1:0] nf;
  logic          beyond;

  // Out-of-range targets collapse to the current floor, i.e. "no move".
  assign tgt = ({1'b0, req_floor} < FloorsNum) ? req_floor : floor_q;

  always_comb begin
    nf = floor_q;
    if (state_q == StMoveUp) begin
      nf = (floor_q == TopFloor) ? floor_q : floor_q + FW'(1);
    end else if (state_q == StMoveDown) begin
      nf = (floor_q == '0) ? floor_q : floor_q - FW'(1);
    end
  end

  assign beyond = (state_q == StMoveUp) ? (tgt > nf) : (tgt < nf);

  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    up_d     = up_q;
    down_d   = down_q;
    door_d   = door_q;
    moving_d = moving_q;
    done_d   = done_q;
    trav_d   = trav_q;
    dwell_d  = dwell_q;

    unique case (state_q)
      StIdle: begin
        up_d     = 1'b0;
        down_d   = 1'b0;
        door_d   = 1'b0;
        moving_d = 1'b0;
        done_d   = '0;
        if (req_vec[floor_q]) begin
          state_d = StDoorOpen;
          door_d  = 1'b1;
          done_d  = OneHot0 << floor_q;
          dwell_d = '0;
        end else if (tgt > floor_q) begin
          state_d  = StMoveUp;
          up_d     = 1'b1;
          moving_d = 1'b1;
          trav_d   = '0;
        end else if (tgt < floor_q) begin
          state_d  = StMoveDown;
          down_d   = 1'b1;
          moving_d = 1'b1;
          trav_d   = '0;
        end
      end

      StMoveUp, StMoveDown: begin
        if (trav_q == TravLast) begin
          trav_d  = '0;
          floor_d = nf;
          if (req_vec[nf]) begin
            // Direction flags are kept so the arbiter continues this sweep.
            state_d  = StDoorOpen;
            door_d   = 1'b1;
            moving_d = 1'b0;
            done_d   = OneHot0 << nf;
            dwell_d  = '0;
          end else if (!beyond) begin
            state_d  = StIdle;
            up_d     = 1'b0;
            down_d   = 1'b0;
            moving_d = 1'b0;
          end
        end else begin
          trav_d = trav_q + TW'(1);
        end
      end

      StDoorOpen: begin
        if (door_hold) begin
          dwell_d = '0;
        end else if (dwell_q == DwellLast) begin
          dwell_d = '0;
          door_d  = 1'b0;
          done_d  = '0;
          trav_d  = '0;
          if (tgt > floor_q) begin
            state_d  = StMoveUp;
            up_d     = 1'b1;
            down_d   = 1'b0;
            moving_d = 1'b1;
          end else if (tgt < floor_q) begin
            state_d  = StMoveDown;
            up_d     = 1'b0;
            down_d   = 1'b1;
            moving_d = 1'b1;
          end else begin
            state_d = StIdle;
            up_d    = 1'b0;
            down_d  = 1'b0;
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      floor_q  <= '0;
      up_q     <= 1'b0;
      down_q   <= 1'b0;
      door_q   <= 1'b0;
      moving_q <= 1'b0;
      done_q   <= '0;
      trav_q   <= '0;
      dwell_q  <= '0;
    end else begin
      state_q  <= state_d;
      floor_q  <= floor_d;
      up_q     <= up_d;
      down_q   <= down_d;
      door_q   <= door_d;
      moving_q <= moving_d;
      done_q   <= done_d;
      trav_q   <= trav_d;
      dwell_q  <= dwell_d;
    end
  end

  assign curr_floor   = floor_q;
  assign up           = up_q;
  assign down         = down_q;
  assign door_open    = door_q;
  assign moving       = moving_q;
  assign request_done = done_q;

endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// Bench for elevator_motion_ctrl: directed scenarios plus random traffic, all
// compared against a countdown-based behavioural model of the cabin.
module tb_elevator_motion_ctrl;

  localparam int FLOORS = 5;
  localparam int TRAVEL = 8;
  localparam int DWELL  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req_floor;
  logic [4:0] req_vec;
  logic       door_hold;
  logic [2:0] curr_floor;
  logic       up;
  logic       down;
  logic [4:0] request_done;
  logic       door_open;
  logic       moving;

  logic [11:0] obs;
  assign obs = {curr_floor, up, down, door_open, moving, request_done};

  int checks = 0;
  int errors = 0;

  // Model: phase 0 = parked, 1 = travelling, 2 = door open; dir is -1/0/+1.
  int m_floor, m_dir, m_phase, m_trav_left, m_dwell_left;

  elevator_motion_ctrl #(
    .FLOORS_NUM(FLOORS),
    .FLOOR_TRAVEL_CYCLES(TRAVEL),
    .DOOR_OPEN_CYCLES(DWELL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_floor(req_floor),
    .req_vec(req_vec),
    .door_hold(door_hold),
    .curr_floor(curr_floor),
    .up(up),
    .down(down),
    .request_done(request_done),
    .door_open(door_open),
    .moving(moving)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic model_reset();
    m_floor = 0; m_dir = 0; m_phase = 0; m_trav_left = 0; m_dwell_left = 0;
  endtask

  task automatic start_toward(input int tgt);
    if (tgt > m_floor) begin
      m_phase = 1; m_dir = 1; m_trav_left = TRAVEL;
    end else if (tgt < m_floor) begin
      m_phase = 1; m_dir = -1; m_trav_left = TRAVEL;
    end else begin
      m_phase = 0; m_dir = 0;
    end
  endtask

  task automatic model_step(input logic [2:0] rf, input logic [4:0] rv, input logic hold);
    int tgt;
    int nf;
    tgt = (int'(rf) < FLOORS) ? int'(rf) : m_floor;
    if (m_phase == 0) begin
      if (rv[m_floor]) begin
        m_phase = 2; m_dwell_left = DWELL;
      end else begin
        start_toward(tgt);
      end
    end else if (m_phase == 1) begin
      m_trav_left--;
      if (m_trav_left == 0) begin
        nf = m_floor + m_dir;
        if (nf < 0) nf = 0;
        if (nf > FLOORS - 1) nf = FLOORS - 1;
        m_floor = nf;
        if (rv[nf]) begin
          m_phase = 2; m_dwell_left = DWELL;
        end else if ((m_dir > 0 && tgt > nf) || (m_dir < 0 && tgt < nf)) begin
          m_trav_left = TRAVEL;
        end else begin
          m_phase = 0; m_dir = 0;
        end
      end
    end else begin
      if (hold) begin
        m_dwell_left = DWELL;
      end else begin
        m_dwell_left--;
        if (m_dwell_left == 0) start_toward(tgt);
      end
    end
  endtask

  function automatic logic [11:0] model_out();
    logic [4:0] rd;
    logic [2:0] fl;
    rd = '0;
    fl = 3'(m_floor);
    if (m_phase == 2) rd[m_floor] = 1'b1;
    return {fl, m_dir > 0, m_dir < 0, m_phase == 2, m_phase == 1, rd};
  endfunction

  // One clock: model samples the same inputs as the DUT; the bench then plays
  // arbiter and drops the request of a floor whose door is open.
  task automatic tick();
    @(posedge clk);
    model_step(req_floor, req_vec, door_hold);
    #1;
    if (m_phase == 2) req_vec[m_floor] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_floor = '0; req_vec = '0; door_hold = 1'b0;
    @(posedge clk);
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_floor = '0; req_vec = '0; door_hold = 1'b0;
    #3 rst = 1'b1;
    #1;
    checks++;
    if (obs !== 12'h000) $display("FAIL reset_async got %h exp %h", obs, 12'h000);
    if (obs !== 12'h000) errors++;
    do_reset();
    checks++;
    if (obs !== model_out()) begin
      errors++;
      $display("FAIL reset_release got %h exp %h", obs, model_out());
    end
  endtask

  task automatic test_single_trip();
    do_reset();
    req_floor = 3'd2; req_vec = 5'b00100;
    for (int c = 1; c <= 22; c++) begin
      tick();
      checks++;
      if (obs !== model_out()) begin
        errors++;
        $display("FAIL single_trip c=%0d got %h exp %h", c, obs, model_out());
      end
      if (c == 1) begin
        checks++;
        if (up !== 1'b1 || moving !== 1'b1) begin
          errors++;
          $display("FAIL single_trip_start got up=%b mv=%b exp 1 1", up, moving);
        end
      end
      if (c == 9 || c == 16) begin
        checks++;
        if (curr_floor !== 3'd1) begin
          errors++;
          $display("FAIL single_trip_floor1 c=%0d got %0d exp 1", c, curr_floor);
        end
      end
      if (c == 17 || c == 20) begin
        checks++;
        if (curr_floor !== 3'd2 || door_open !== 1'b1 || request_done !== 5'b00100) begin
          errors++;
          $display("FAIL single_trip_door c=%0d got fl=%0d door=%b rd=%b exp 2 1 00100",
                   c, curr_floor, door_open, request_done);
        end
      end
      if (c == 21) begin
        checks++;
        if (door_open !== 1'b0 || up !== 1'b0 || moving !== 1'b0) begin
          errors++;
          $display("FAIL single_trip_idle got door=%b up=%b mv=%b exp 0 0 0",
                   door_open, up, moving);
        end
      end
    end
  endtask

  task automatic test_intermediate_stop();
    do_reset();
    req_floor = 3'd4; req_vec = 5'b10100;
    for (int c = 1; c <= 42; c++) begin
      tick();
      checks++;
      if (obs !== model_out()) begin
        errors++;
        $display("FAIL mid_stop c=%0d got %h exp %h", c, obs, model_out());
      end
      if (c == 17 || c == 20) begin
        checks++;
        if (curr_floor !== 3'd2 || door_open !== 1'b1 || up !== 1'b1) begin
          errors++;
          $display("FAIL mid_stop_hold_up c=%0d got fl=%0d door=%b up=%b exp 2 1 1",
                   c, curr_floor, door_open, up);
        end
      end
      if (c == 21) begin
        checks++;
        if (moving !== 1'b1 || door_open !== 1'b0 || up !== 1'b1) begin
          errors++;
          $display("FAIL mid_stop_resume got mv=%b door=%b up=%b exp 1 0 1",
                   moving, door_open, up);
        end
      end
      if (c == 37) begin
        checks++;
        if (curr_floor !== 3'd4 || door_open !== 1'b1 || request_done !== 5'b10000) begin
          errors++;
          $display("FAIL mid_stop_top got fl=%0d door=%b rd=%b exp 4 1 10000",
                   curr_floor, door_open, request_done);
        end
      end
    end
  endtask

  task automatic test_idle_door();
    do_reset();
    req_floor = 3'd0; req_vec = 5'b00001;
    tick();
    checks++;
    if (door_open !== 1'b1 || request_done !== 5'b00001 || moving !== 1'b0 ||
        curr_floor !== 3'd0) begin
      errors++;
      $display("FAIL idle_door got door=%b rd=%b mv=%b fl=%0d exp 1 00001 0 0",
               door_open, request_done, moving, curr_floor);
    end
  endtask

  task automatic test_door_hold();
    do_reset();
    req_floor = 3'd0; req_vec = 5'b00001;
    tick();
    door_hold = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      checks++;
      if (door_open !== 1'b1 || obs !== model_out()) begin
        errors++;
        $display("FAIL door_hold_held c=%0d got %h exp %h", c, obs, model_out());
      end
    end
    door_hold = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (door_open !== (k < 4) || obs !== model_out()) begin
        errors++;
        $display("FAIL door_hold_release k=%0d got door=%b exp %b", k, door_open, k < 4);
      end
    end
  endtask

  task automatic test_reversal();
    do_reset();
    req_floor = 3'd3; req_vec = 5'b01000;
    for (int c = 1; c <= 37; c++) begin
      tick();
      checks++;
      if (obs !== model_out()) begin
        errors++;
        $display("FAIL reversal c=%0d got %h exp %h", c, obs, model_out());
      end
      if (c == 25) req_floor = 3'd1;
      if (c == 29) begin
        checks++;
        if (down !== 1'b1 || up !== 1'b0 || moving !== 1'b1) begin
          errors++;
          $display("FAIL reversal_dir got up=%b dn=%b mv=%b exp 0 1 1", up, down, moving);
        end
      end
      if (c == 37) begin
        checks++;
        if (curr_floor !== 3'd2) begin
          errors++;
          $display("FAIL reversal_floor got %0d exp 2", curr_floor);
        end
      end
    end
  endtask

  task automatic test_reset_mid_travel();
    do_reset();
    req_floor = 3'd2; req_vec = 5'b00100;
    for (int c = 1; c <= 27; c++) begin
      tick();
      if (c == 21) req_floor = 3'd0;
      checks++;
      if (obs !== model_out()) begin
        errors++;
        $display("FAIL mid_travel_setup c=%0d got %h exp %h", c, obs, model_out());
      end
    end
    checks++;
    if (down !== 1'b1 || curr_floor !== 3'd2 || moving !== 1'b1) begin
      errors++;
      $display("FAIL mid_travel_pre got dn=%b fl=%0d mv=%b exp 1 2 1", down, curr_floor, moving);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs !== 12'h000) begin
      errors++;
      $display("FAIL mid_travel_async got %h exp %h", obs, 12'h000);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; req_floor = 3'd7; req_vec = '0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      checks++;
      if (obs !== model_out() || obs !== 12'h000) begin
        errors++;
        $display("FAIL out_of_range c=%0d got %h exp %h", c, obs, 12'h000);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) req_floor = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) req_vec[$urandom_range(0, 4)] = 1'b1;
      door_hold = ($urandom_range(0, 11) == 0);
      tick();
      checks++;
      if (obs !== model_out()) begin
        errors++;
        $display("FAIL random c=%0d got %h exp %h", c, obs, model_out());
      end
      checks++;
      if (up === 1'b1 && down === 1'b1) begin
        errors++;
        $display("FAIL random_dir_excl c=%0d got up=1 dn=1 exp not both", c);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_trip();
    test_intermediate_stop();
    test_idle_door();
    test_door_hold();
    test_reversal();
    test_reset_mid_travel();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
